iter_shift_unit: RTL and testbench

- Multi-cycle shift/rotate execution unit for the processor datapath, built around a one-bit-per-cycle shift stage.
- Accepts an operand, a shift amount and an opcode from the ALU issue logic.
- Shifts one bit position per clock and returns the 32-bit result with a one-cycle done pulse to the register-writeback stage.

---
 rtl/iter_shift_if.sv | 25 ++
 rtl/iter_shift_unit.sv | 120 ++++++++++++
 tb/tb_iter_shift_unit.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/iter_shift_if.sv
// Request/response bundle between the ALU issue logic and the iterative shift unit.
// The issue side drives the request; the shift unit returns status and the result.
interface iter_shift_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic               start;
    logic [1:0]         op;
    logic [WIDTH-1:0]   a;
    logic [SHAMT_W-1:0] shamt;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   result;
    logic               carry_out;

    modport master (
        output start, op, a, shamt,
        input  busy, done, result, carry_out
    );

    modport slave (
        input  start, op, a, shamt,
        output busy, done, result, carry_out
    );
endinterface

// File: rtl/iter_shift_unit.sv
// Multi-cycle shift/rotate unit: one bit position per clock, result and carry
// returned with a single-cycle done pulse. Latency is shamt+1 cycles.
module iter_shift_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    iter_shift_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROL = 2'b11
    } op_e;

    localparam logic [SHAMT_W-1:0] CNT_ONE = {{(SHAMT_W-1){1'b0}}, 1'b1};

    state_e             state;
    op_e                op_q;
    logic [WIDTH-1:0]   data;
    logic [SHAMT_W-1:0] count;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   result_q;
    logic               carry_q;

    logic [WIDTH-1:0]   step_data;
    logic               step_carry;

    // NOTE: every output of always_comb gets a default first, so no path
    // through the case statement can leave a value held (no latch).
    always_comb begin
        step_data  = data;
        step_carry = carry_q;
        unique case (op_q)
            OP_SLL: begin
                step_data  = {data[WIDTH-2:0], 1'b0};
                step_carry = data[WIDTH-1];
            end
            OP_SRL: begin
                step_data  = {1'b0, data[WIDTH-1:1]};
                step_carry = data[0];
            end
            OP_SRA: begin
                step_data  = {data[WIDTH-1], data[WIDTH-1:1]};
                step_carry = data[0];
            end
            OP_ROL: begin
                step_data  = {data[WIDTH-2:0], data[WIDTH-1]};
                step_carry = data[WIDTH-1];
            end
        endcase
    end

    // NOTE: all state here uses non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            op_q     <= OP_SLL;
            data     <= '0;
            count    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                // DONE accepts a new request exactly like IDLE (back-to-back).
                S_IDLE, S_DONE: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                    if (bus.start) begin
                        data    <= bus.a;
                        carry_q <= 1'b0;
                        if (bus.shamt == '0) begin
                            state    <= S_DONE;
                            done_q   <= 1'b1;
                            result_q <= bus.a;
                        end else begin
                            state  <= S_SHIFT;
                            busy_q <= 1'b1;
                            count  <= bus.shamt;
                            op_q   <= op_e'(bus.op);
                        end
                    end
                end
                S_SHIFT: begin
                    data    <= step_data;
                    carry_q <= step_carry;
                    count   <= count - CNT_ONE;
                    if (count == CNT_ONE) begin
                        state    <= S_DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= step_data;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.carry_out = carry_q;
endmodule

// File: tb/tb_iter_shift_unit.sv
// Self-checking bench for iter_shift_unit: directed cases plus random operations
// compared against an arithmetic reference model.
module tb_iter_shift_unit;
    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_err    = 0;

    iter_shift_if #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) bus ();

    iter_shift_unit #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: whole-word shift arithmetic; carry is the last bit to leave.
    function automatic logic [32:0] model(input logic [1:0] op, input logic [31:0] a, input int sh);
        logic [31:0] r;
        logic        c;
        c = 1'b0;
        case (op)
            2'b00: begin r = a << sh; if (sh > 0) c = a[32-sh]; end
            2'b01: begin r = a >> sh; if (sh > 0) c = a[sh-1]; end
            2'b10: begin r = $signed(a) >>> sh; if (sh > 0) c = a[sh-1]; end
            default: begin
                r = (sh == 0) ? a : ((a << sh) | (a >> (32 - sh)));
                if (sh > 0) c = r[0];
            end
        endcase
        return {c, r};
    endfunction

    task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [4:0] sh);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.shamt = sh;
    endtask

    // Counts negedges until done; with noise, scrambles inputs and pulses start while busy.
    task automatic wait_done(input bit noise, output int cyc, output int bcyc);
        cyc  = 0;
        bcyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cyc++;
            if (bus.busy) bcyc++;
            if (bus.done) begin
                if (noise) bus.start = 1'b0;
                return;
            end
            if (noise) begin
                bus.start = bus.busy & 1'($urandom_range(0, 1));
                bus.a     = $urandom;
                bus.shamt = SHAMT_W'($urandom);
                bus.op    = 2'($urandom);
            end
        end
        bus.start = 1'b0;
        check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [4:0] sh, input logic [31:0] exp_r, input logic exp_c);
        int cyc;
        int bcyc;
        logic [31:0] held;
        @(negedge clk);
        drive(op, a, sh);
        wait_done(1'b1, cyc, bcyc);
        held = bus.result;
        check({tag, ".result"}, bus.result, exp_r);
        check({tag, ".carry"}, 32'(bus.carry_out), 32'(exp_c));
        check({tag, ".latency"}, cyc, int'(sh) + 1);
        check({tag, ".busy_cycles"}, bcyc, int'(sh));
        @(negedge clk);
        check({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
        check({tag, ".hold"}, bus.result, exp_r);
        check({tag, ".hold_vs_done"}, bus.result, held);
    endtask

    initial begin
        int          cyc;
        int          bcyc;
        int          done_seen;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [4:0]  rsh;
        logic [32:0] m;

        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.shamt = '0;

        repeat (2) @(negedge clk);
        check("rst.busy", 32'(bus.busy), 32'd0);
        check("rst.done", 32'(bus.done), 32'd0);
        check("rst.result", bus.result, 32'd0);
        check("rst.carry", 32'(bus.carry_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("sll31", 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0);
        run_op("sra4",  2'b10, 32'h8000_0000, 5'd4,  32'hF800_0000, 1'b0);
        run_op("srl1",  2'b01, 32'h8000_0001, 5'd1,  32'h4000_0000, 1'b1);
        run_op("rol4",  2'b11, 32'h8000_0001, 5'd4,  32'h0000_0018, 1'b0);
        run_op("zero",  2'($urandom), 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1'b0);

        // Back-to-back: start stays high from the first request through its DONE.
        @(negedge clk);
        drive(2'b11, 32'h0000_00F1, 5'd3);
        @(negedge clk);
        drive(2'b00, 32'h0000_0003, 5'd2);
        wait_done(1'b0, cyc, bcyc);
        check("b2b.first_result", bus.result, 32'h0000_0788);
        check("b2b.first_latency", cyc, 3);
        wait_done(1'b1, cyc, bcyc);
        check("b2b.second_result", bus.result, 32'h0000_000C);
        check("b2b.second_carry", 32'(bus.carry_out), 32'd0);
        check("b2b.second_latency", cyc, 3);
        @(negedge clk);
        check("b2b.done_pulse", 32'(bus.done), 32'd0);

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom);
            ra  = $urandom;
            rsh = 5'($urandom);
            if (i % 8 == 0) rsh = 5'd31;
            m = model(rop, ra, int'(rsh));
            run_op("rand", rop, ra, rsh, m[31:0], m[32]);
        end

        // Asynchronous reset during the eighth shift cycle of a 20-bit shift.
        run_op("pre_rst", 2'b01, 32'hF0F0_F0F0, 5'd4, 32'h0F0F_0F0F, 1'b0);
        @(negedge clk);
        drive(2'b00, 32'hA5A5_0003, 5'd20);
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst.busy", 32'(bus.busy), 32'd0);
        check("mid_rst.done", 32'(bus.done), 32'd0);
        check("mid_rst.result", bus.result, 32'd0);
        check("mid_rst.carry", 32'(bus.carry_out), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        check("mid_rst.no_done", done_seen, 0);
        run_op("post_rst", 2'b00, 32'h0000_0001, 5'd1, 32'h0000_0002, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
